weight_sparse_encoder: RTL and testbench

Upstream feeder of the sparse weight buffer stage. It accepts dense 3x3 kernels, one weight per cycle in row-major order, and compresses each kernel. Every nonzero weight goes out as a serial data write. One KERNEL_SIZE-bit zero/nonzero flag word is written per kernel. Its write ports drive the weight stage's wr_req_wei/wr_data_wei and wr_req_wei_flag/wr_data_wei_flag inputs directly.

---
 rtl/weight_sparse_encoder_pkg.sv | 30 +++
 rtl/weight_sparse_encoder_if.sv | 25 ++
 rtl/weight_sparse_encoder_kernel_flag_accum.sv | 50 +++++
 rtl/weight_sparse_encoder.sv | 132 +++++++++++++
 tb/tb_weight_sparse_encoder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_sparse_encoder_pkg.sv
// rtl/weight_sparse_encoder_pkg.sv - shared sizes, FSM encoding and magnitude helper for the sparse weight encoder
package weight_sparse_encoder_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int KERNEL_WIDTH    = 3;
    localparam int KERNEL_SIZE     = KERNEL_WIDTH * KERNEL_WIDTH;
    localparam int WEI_INDEX_WIDTH = 2;
    localparam int KNUM_WIDTH      = 8;
    localparam int WIDX_WIDTH      = $clog2(KERNEL_SIZE);
    localparam int ROW_NNZ_WIDTH   = WEI_INDEX_WIDTH * KERNEL_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    // Two's complement magnitude; the most negative code saturates to the largest positive one.
    function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] v);
        if (!v[DATA_WIDTH-1]) begin
            return v;
        end
        if (v == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return -v;
    endfunction

endpackage

// File: rtl/weight_sparse_encoder_if.sv
// rtl/weight_sparse_encoder_if.sv - dense weight input stream and sparse write ports of the encoder
interface weight_sparse_encoder_if;
    import weight_sparse_encoder_pkg::*;

    logic                     in_valid;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     in_ready;
    logic                     wr_req_wei;
    logic [DATA_WIDTH-1:0]    wr_data_wei;
    logic                     wr_req_wei_flag;
    logic [KERNEL_SIZE-1:0]   wr_data_wei_flag;
    logic [ROW_NNZ_WIDTH-1:0] row_nnz;

    // master is the encoder side, slave is the feeder plus the weight buffer stage
    modport master (
        input  in_valid, in_data,
        output in_ready, wr_req_wei, wr_data_wei, wr_req_wei_flag, wr_data_wei_flag, row_nnz
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, wr_req_wei, wr_data_wei, wr_req_wei_flag, wr_data_wei_flag, row_nnz
    );

endinterface

// File: rtl/weight_sparse_encoder_kernel_flag_accum.sv
// rtl/weight_sparse_encoder_kernel_flag_accum.sv - per-kernel nonzero flag word and per-row nonzero counts
module weight_sparse_encoder_kernel_flag_accum
    import weight_sparse_encoder_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     accept,
    input  logic                     clear,
    input  logic [WIDX_WIDTH-1:0]    widx,
    input  logic                     nonzero,
    output logic [KERNEL_SIZE-1:0]   flag,
    output logic [ROW_NNZ_WIDTH-1:0] row_nnz
);

    logic [KERNEL_SIZE-1:0]   flag_q;
    logic [ROW_NNZ_WIDTH-1:0] row_nnz_q;
    logic [WIDX_WIDTH-1:0]    row;

    assign row = widx / WIDX_WIDTH'(KERNEL_WIDTH);

    // Outputs already include the weight being accepted, so the last weight lands in the committed word.
    always_comb begin
        flag    = flag_q;
        row_nnz = row_nnz_q;
        if (accept && nonzero) begin
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                if (widx == WIDX_WIDTH'(i)) begin
                    flag[i] = 1'b1;
                end
            end
            for (int r = 0; r < KERNEL_WIDTH; r++) begin
                if (row == WIDX_WIDTH'(r)) begin
                    row_nnz[r*WEI_INDEX_WIDTH +: WEI_INDEX_WIDTH] =
                        row_nnz_q[r*WEI_INDEX_WIDTH +: WEI_INDEX_WIDTH] + WEI_INDEX_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            flag_q    <= '0;
            row_nnz_q <= '0;
        end else begin
            flag_q    <= flag;
            row_nnz_q <= row_nnz;
        end
    end

endmodule

// File: rtl/weight_sparse_encoder.sv
// rtl/weight_sparse_encoder.sv - dense 3x3 kernel to sparse weight/flag writer; WEI_PRUNE_EN adds magnitude pruning
module weight_sparse_encoder
    import weight_sparse_encoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KNUM_WIDTH-1:0] num_kernels,
`ifdef WEI_PRUNE_EN
    input  logic [DATA_WIDTH-1:0] prune_thr,
`endif
    output logic                  busy,
    output logic                  done,
    weight_sparse_encoder_if.master bus
);

    localparam logic [WIDX_WIDTH-1:0] LAST_WIDX = WIDX_WIDTH'(KERNEL_SIZE - 1);

    state_t                   state;
    logic [WIDX_WIDTH-1:0]    widx;
    logic [KNUM_WIDTH-1:0]    kcnt;
    logic                     accept;
    logic                     nonzero;
    logic                     clear;
    logic [KERNEL_SIZE-1:0]   flag_word;
    logic [ROW_NNZ_WIDTH-1:0] row_word;

    assign accept = bus.in_valid && bus.in_ready;
    assign clear  = (state == ST_COMMIT);

`ifdef WEI_PRUNE_EN
    logic [DATA_WIDTH-1:0] thr;

    // Threshold is frozen for the whole job so a changing input cannot split a kernel's rule.
    always_ff @(posedge clk) begin
        if (reset) begin
            thr <= '0;
        end else if (state == ST_IDLE && start) begin
            thr <= prune_thr;
        end
    end

    assign nonzero = abs_sat(bus.in_data) > thr;
`else
    assign nonzero = bus.in_data != '0;
`endif

    weight_sparse_encoder_kernel_flag_accum u_accum (
        .clk     (clk),
        .reset   (reset),
        .accept  (accept),
        .clear   (clear),
        .widx    (widx),
        .nonzero (nonzero),
        .flag    (flag_word),
        .row_nnz (row_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= ST_IDLE;
            widx                 <= '0;
            kcnt                 <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            bus.in_ready         <= 1'b0;
            bus.wr_req_wei       <= 1'b0;
            bus.wr_data_wei      <= '0;
            bus.wr_req_wei_flag  <= 1'b0;
            bus.wr_data_wei_flag <= '0;
            bus.row_nnz          <= '0;
        end else begin
            bus.wr_req_wei      <= 1'b0;
            bus.wr_req_wei_flag <= 1'b0;
            done                <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        kcnt <= num_kernels;
                        busy <= 1'b1;
                        if (num_kernels == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state        <= ST_LOAD;
                            bus.in_ready <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (nonzero) begin
                            bus.wr_req_wei  <= 1'b1;
                            bus.wr_data_wei <= bus.in_data;
                        end
                        if (widx == LAST_WIDX) begin
                            widx                 <= '0;
                            state                <= ST_COMMIT;
                            bus.in_ready         <= 1'b0;
                            bus.wr_req_wei_flag  <= 1'b1;
                            bus.wr_data_wei_flag <= flag_word;
                            bus.row_nnz          <= row_word;
                            done                 <= (kcnt == KNUM_WIDTH'(1));
                        end else begin
                            widx <= widx + WIDX_WIDTH'(1);
                        end
                    end
                end
                ST_COMMIT: begin
                    kcnt <= kcnt - KNUM_WIDTH'(1);
                    if (kcnt == KNUM_WIDTH'(1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state        <= ST_LOAD;
                        bus.in_ready <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    bus.in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_sparse_encoder.sv
// tb/tb_weight_sparse_encoder.sv - table-driven self-checking bench for weight_sparse_encoder
module tb_weight_sparse_encoder;
    import weight_sparse_encoder_pkg::*;

    typedef struct {
        logic [7:0] w [9];
        logic [8:0] flag;
        logic [5:0] rnnz;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] num_kernels;
    logic       busy;
    logic       done;
`ifdef WEI_PRUNE_EN
    logic [7:0] prune_thr;
`endif

    weight_sparse_encoder_if bus ();

    weight_sparse_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_kernels (num_kernels),
`ifdef WEI_PRUNE_EN
        .prune_thr   (prune_thr),
`endif
        .busy        (busy),
        .done        (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int low_cnt = 0;
    int ready_cnt = 0;
    int thr_m = 0;
    logic done_flag;
    logic [7:0] wr_q [$];
    logic [8:0] fl_q [$];
    logic [5:0] rn_q [$];
    int job_q [$];
    vec_t vt [6];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.wr_req_wei) wr_q.push_back(bus.wr_data_wei);
        if (bus.wr_req_wei_flag) begin
            fl_q.push_back(bus.wr_data_wei_flag);
            rn_q.push_back(bus.row_nnz);
        end
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_flag = bus.wr_req_wei_flag;
        end
        if (busy && !bus.in_ready) low_cnt++;
        if (bus.in_ready) ready_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit keep(input logic [7:0] w);
        int a;
        a = int'($signed(w));
        if (a < 0) a = -a;
        if (a > 127) a = 127;
        return a > thr_m;
    endfunction

    task automatic do_start(input int nk);
        @(negedge clk);
        start       = 1'b1;
        num_kernels = nk[7:0];
        start_cyc   = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_weight(input logic [7:0] w, input int gap);
        int g;
        g = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        while (!bus.in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic clear_logs();
        wr_q.delete();
        fl_q.delete();
        rn_q.delete();
        done_cnt  = 0;
        low_cnt   = 0;
        ready_cnt = 0;
        done_flag = 1'b0;
    endtask

    task automatic run_job(input int nk, input bit gap, input bit stray, input string tag);
        logic [7:0] exp_q [$];
        int g;
        clear_logs();
        do_start(nk);
        for (int k = 0; k < nk; k++) begin
            for (int i = 0; i < 9; i++) begin
                if (stray && k == 0 && i == 4) begin
                    start       = 1'b1;
                    num_kernels = 8'd5;
                    @(posedge clk);
                    #1 start    = 1'b0;
                end
                send_weight(vt[job_q[k]].w[i], gap ? int'($urandom_range(0, 2)) : 0);
            end
        end
        g = 0;
        while (done_cnt == 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (done_cnt == 0) chk({tag, "_done_timeout"}, 0, 1);
        repeat (2) @(negedge clk);
        for (int k = 0; k < nk; k++)
            for (int i = 0; i < 9; i++)
                if (keep(vt[job_q[k]].w[i])) exp_q.push_back(vt[job_q[k]].w[i]);
        chk({tag, "_nwrites"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            chk({tag, "_wdata"}, wr_q[i], exp_q[i]);
        chk({tag, "_nflags"}, fl_q.size(), nk);
        for (int k = 0; k < nk && k < fl_q.size(); k++) begin
            chk({tag, "_flag"}, fl_q[k], vt[job_q[k]].flag);
            chk({tag, "_row_nnz"}, rn_q[k], vt[job_q[k]].rnnz);
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
        if (nk > 0) chk({tag, "_done_with_flag"}, done_flag, 1);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wr_req_wei"}, bus.wr_req_wei, 0);
        chk({tag, "_wr_data_wei"}, bus.wr_data_wei, 0);
        chk({tag, "_wr_req_flag"}, bus.wr_req_wei_flag, 0);
        chk({tag, "_wr_data_flag"}, bus.wr_data_wei_flag, 0);
        chk({tag, "_row_nnz"}, bus.row_nnz, 0);
    endtask

    initial begin
        vt[0].w = '{8'h00, 8'h05, 8'h00, 8'hFD, 8'h00, 8'h00, 8'h07, 8'h00, 8'h01};
        vt[0].flag = 9'h14A; vt[0].rnnz = 6'h25;
        vt[1].w = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        vt[1].flag = 9'h1FF; vt[1].rnnz = 6'h3F;
        vt[2].w = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[2].flag = 9'h000; vt[2].rnnz = 6'h00;
        vt[3].w = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        vt[3].flag = 9'h101; vt[3].rnnz = 6'h11;
        vt[4].w = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[4].flag = 9'h010; vt[4].rnnz = 6'h04;
        vt[5].w = '{8'h02, 8'hFD, 8'h04, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
        vt[5].flag = 9'h00C; vt[5].rnnz = 6'h05;

        reset        = 1'b1;
        start        = 1'b0;
        num_kernels  = 8'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
`ifdef WEI_PRUNE_EN
        prune_thr    = 8'd0;
`endif
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;

        // single kernels, gapless, latency start+10
        for (int v = 0; v < 5; v++) begin
            job_q = '{v};
            run_job(1, 1'b0, 1'b0, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_latency", v), done_cyc - start_cyc, 10);
        end

        job_q = '{1, 1, 1};
        run_job(3, 1'b0, 1'b0, "ones3");
        chk("ones3_commit_cycles", low_cnt, 3);

        clear_logs();
        do_start(0);
        repeat (3) @(negedge clk);
        chk("nk0_done_cnt", done_cnt, 1);
        chk("nk0_latency", done_cyc - start_cyc, 1);
        chk("nk0_writes", wr_q.size() + fl_q.size(), 0);
        chk("nk0_ready_cnt", ready_cnt, 0);
        chk("nk0_busy_after", busy, 0);

        job_q = '{0, 3};
        run_job(2, 1'b1, 1'b1, "gaps");

        // reset after 4 weights of the second kernel
        clear_logs();
        do_start(2);
        for (int i = 0; i < 9; i++) send_weight(vt[3].w[i], 0);
        for (int i = 0; i < 4; i++) send_weight(vt[1].w[i], 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midrst");
        reset = 1'b0;
        chk("midrst_nflags", fl_q.size(), 1);
        if (fl_q.size() > 0) chk("midrst_flag0", fl_q[0], 9'h101);
        chk("midrst_nwrites", wr_q.size(), 6);
        job_q = '{4};
        run_job(1, 1'b0, 1'b0, "after_rst");

`ifdef WEI_PRUNE_EN
        thr_m     = 3;
        prune_thr = 8'd3;
        job_q = '{5};
        run_job(1, 1'b0, 1'b0, "prune");
        if (wr_q.size() == 2) begin
            chk("prune_w0", wr_q[0], 8'h04);
            chk("prune_w1", wr_q[1], 8'h80);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
